// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: bit-serial pattern transmitter.
// Loads a right-aligned pattern word and shifts it out MSB-first, one bit per
// clock. The pattern repeats reps+1 times, with gap idle cycles between
// repetitions, and a one-cycle done pulse follows the final bit. All inputs
// are captured into shadow registers on the accepting start edge, so input
// changes during a transmission have no effect.
module seq_pattern_tx #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int GAP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [REP_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  // Width of a bit index into the pattern word.
  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [PAT_W-1:0] pat_r;
  logic [IDX_W-1:0] top_r;
  logic [REP_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_r;
  logic [GAP_W-1:0] gap_cnt;
  logic [IDX_W-1:0] bit_idx;

  logic [IDX_W-1:0] start_top;
  logic [IDX_W-1:0] next_idx;

  // Index of the first (most significant) bit to send; a zero or oversized
  // length falls back to the full pattern width.
  always_comb begin
    start_top = IDX_W'(PAT_W - 1);
    if (pat_len != '0 && pat_len <= LEN_W'(PAT_W)) begin
      start_top = IDX_W'(pat_len - LEN_W'(1));
    end
  end

  // Index of the bit that follows the one currently on x_out.
  always_comb begin
    next_idx = bit_idx - IDX_W'(1);
  end

  // Transmitter FSM with registered serial outputs and repetition/gap counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pat_r       <= '0;
      top_r       <= '0;
      rep_cnt     <= '0;
      gap_r       <= '0;
      gap_cnt     <= '0;
      bit_idx     <= '0;
      x_out       <= 1'b0;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (abort && state != IDLE) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      bit_idx     <= '0;
      rep_cnt     <= '0;
      x_out       <= 1'b0;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          x_out       <= 1'b0;
          x_valid     <= 1'b0;
          frame_start <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          if (start) begin
            pat_r       <= pattern;
            top_r       <= start_top;
            rep_cnt     <= reps;
            gap_r       <= gap;
            gap_cnt     <= '0;
            bit_idx     <= start_top;
            x_out       <= pattern[start_top];
            x_valid     <= 1'b1;
            frame_start <= 1'b1;
            busy        <= 1'b1;
            state       <= SHIFT;
          end
        end

        SHIFT: begin
          if (bit_idx != '0) begin
            bit_idx     <= next_idx;
            x_out       <= pat_r[next_idx];
            x_valid     <= 1'b1;
            frame_start <= 1'b0;
          end else if (rep_cnt == '0) begin
            x_out       <= 1'b0;
            x_valid     <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            rep_cnt <= rep_cnt - REP_W'(1);
            if (gap_r != '0) begin
              gap_cnt     <= gap_r;
              x_out       <= 1'b0;
              x_valid     <= 1'b0;
              frame_start <= 1'b0;
              state       <= GAP;
            end else begin
              bit_idx     <= top_r;
              x_out       <= pat_r[top_r];
              x_valid     <= 1'b1;
              frame_start <= 1'b1;
            end
          end
        end

        GAP: begin
          if (gap_cnt == GAP_W'(1)) begin
            gap_cnt     <= '0;
            bit_idx     <= top_r;
            x_out       <= pat_r[top_r];
            x_valid     <= 1'b1;
            frame_start <= 1'b1;
            state       <= SHIFT;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed and randomized checks of seq_pattern_tx against
// a cycle-by-cycle output list built from the transmission rules.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] pat_len;
  logic [3:0] reps;
  logic [2:0] gap;
  logic       x_out;
  logic       x_valid;
  logic       frame_start;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic xo;
    logic xv;
    logic fs;
    logic bz;
    logic dn;
  } exp_t;

  exp_t expq[$];

  seq_pattern_tx #(.PAT_W(8), .LEN_W(4), .REP_W(4), .GAP_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .pattern(pattern),
    .pat_len(pat_len),
    .reps(reps),
    .gap(gap),
    .x_out(x_out),
    .x_valid(x_valid),
    .frame_start(frame_start),
    .busy(busy),
    .done(done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    exp_t o;
    o = {x_out, x_valid, frame_start, busy, done};
    total++;
    assert (o === e) else begin
      bad++;
      $error("[TB] FAIL %s observed{xo,xv,fs,busy,done}=%b expected=%b", tag, o, e);
    end
  endtask

  // Expected per-cycle outputs of one complete transmission, starting with the
  // cycle after the start edge and ending with the first idle cycle.
  task automatic buildExpected(input logic [7:0] p, input logic [3:0] len,
                               input logic [3:0] rp, input logic [2:0] gp);
    int nbits;
    exp_t e;
    nbits = (len == 4'd0 || len > 4'd8) ? 8 : int'(len);
    expq.delete();
    for (int r = 0; r <= int'(rp); r++) begin
      for (int b = nbits - 1; b >= 0; b--) begin
        e = {p[b], 1'b1, (b == nbits - 1), 1'b1, 1'b0};
        expq.push_back(e);
      end
      if (r < int'(rp)) begin
        for (int g = 0; g < int'(gp); g++) begin
          e = 5'b00010;
          expq.push_back(e);
        end
      end
    end
    e = 5'b00011;
    expq.push_back(e);
    e = 5'b00000;
    expq.push_back(e);
  endtask

  // One transmission. stop_at >= 0 interrupts it after that many checked
  // cycles (stop_kind 0 = abort, 1 = reset); with_abort raises abort together
  // with start on the accepting edge.
  task automatic applyStimulus(input string name, input logic [7:0] p, input logic [3:0] len,
                               input logic [3:0] rp, input logic [2:0] gp,
                               input int stop_at, input int stop_kind, input bit with_abort);
    exp_t idle_e;
    idle_e = 5'b00000;
    buildExpected(p, len, rp, gp);
    pattern = p;
    pat_len = len;
    reps    = rp;
    gap     = gp;
    start   = 1'b1;
    abort   = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < expq.size(); i++) begin
      checkOutput($sformatf("%s cyc%0d", name, i + 1), expq[i]);
      pattern = 8'($urandom);
      pat_len = 4'($urandom);
      reps    = 4'($urandom);
      gap     = 3'($urandom);
      if (i == stop_at) begin
        start = 1'b0;
        if (stop_kind == 0) abort = 1'b1;
        else rst = 1'b1;
        tick();
        abort = 1'b0;
        rst   = 1'b0;
        checkOutput($sformatf("%s stop", name), idle_e);
        tick();
        checkOutput($sformatf("%s after_stop", name), idle_e);
        return;
      end
      start = expq[i].bz ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    exp_t idle_e;
    int   len_i;
    int   n;
    idle_e  = 5'b00000;
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = 8'h00;
    pat_len = 4'd0;
    reps    = 4'd0;
    gap     = 3'd0;

    tick();
    start = 1'b1;
    tick();
    checkOutput("reset_holds_start", idle_e);
    start = 1'b0;
    rst   = 1'b0;
    tick();
    checkOutput("reset_state", idle_e);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_in_idle", idle_e);

    applyStimulus("p11011_r0g0", 8'b00011011, 4'd5, 4'd0, 3'd0, -1, 0, 1'b0);
    applyStimulus("p11011_r1g0", 8'b00011011, 4'd5, 4'd1, 3'd0, -1, 0, 1'b0);
    applyStimulus("p11011_r1g2", 8'b00011011, 4'd5, 4'd1, 3'd2, -1, 0, 1'b0);
    applyStimulus("a5_len0", 8'hA5, 4'd0, 4'd0, 3'd0, -1, 0, 1'b0);
    applyStimulus("a5_len15", 8'hA5, 4'd15, 4'd0, 3'd0, -1, 0, 1'b0);
    applyStimulus("a5_len9", 8'hA5, 4'd9, 4'd0, 3'd1, -1, 0, 1'b0);
    applyStimulus("len1_reps15", 8'h01, 4'd1, 4'd15, 3'd0, -1, 0, 1'b0);
    applyStimulus("start_abort_idle", 8'h96, 4'd6, 4'd1, 3'd1, -1, 0, 1'b1);
    applyStimulus("abort_bit3", 8'b00011011, 4'd5, 4'd0, 3'd0, 2, 0, 1'b0);
    applyStimulus("after_abort", 8'b00011011, 4'd5, 4'd0, 3'd0, -1, 0, 1'b0);
    applyStimulus("abort_gap", 8'hC3, 4'd4, 4'd2, 3'd3, 5, 0, 1'b0);
    applyStimulus("abort_done", 8'h3C, 4'd3, 4'd0, 3'd0, 3, 0, 1'b0);
    applyStimulus("rst_mid_shift", 8'hFF, 4'd8, 4'd1, 3'd0, 3, 1, 1'b0);
    applyStimulus("after_rst", 8'b00011011, 4'd5, 4'd0, 3'd0, -1, 0, 1'b0);

    for (int k = 0; k < 25; k++) begin
      logic [7:0] rp_pat;
      logic [3:0] rp_len;
      logic [3:0] rp_reps;
      logic [2:0] rp_gap;
      int stop;
      rp_pat  = 8'($urandom);
      rp_len  = 4'($urandom);
      rp_reps = 4'($urandom_range(0, 3));
      rp_gap  = 3'($urandom);
      len_i   = (rp_len == 4'd0 || rp_len > 4'd8) ? 8 : int'(rp_len);
      n       = len_i * (int'(rp_reps) + 1) + int'(rp_gap) * int'(rp_reps) + 1;
      stop    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      applyStimulus($sformatf("rand%0d", k), rp_pat, rp_len, rp_reps, rp_gap,
                    stop, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
